winograd_drain: RTL and testbench

// Consumer end of the winograd core result interface. Takes the core's two

---
 rtl/winograd_drain.sv | 119 +++++++++++
 tb/tb_winograd_drain.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_drain.sv
// -----------------------------------------------------------------------------
// winograd_drain
//
// Consumer end of the winograd core result interface. Each transferred tile
// carries the core's two partial outputs plus the tile's Winograd correction
// term. The drain removes the correction, accumulates NUM_TILES tiles into
// one exact signed dot product and offers it on a valid/ready result port.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous abort of the partial accumulation
//   tile_valid_i  pair_i/corr_i hold a tile
//   tile_ready_o  drain can take a tile this cycle (combinational)
//   pair_i        core partial outputs out[0], out[1] (signed, OUT_SIZE each)
//   corr_i        tile correction term (signed, OUT_SIZE)
//   res_valid_o   res_o holds a finished dot product
//   res_ready_i   downstream takes res_o
//   res_o         signed dot product over NUM_TILES tiles
//   tile_cnt_o    tiles accumulated in the current product
//   state_o       FSM state (0 = IDLE, 1 = ACCUM), debug visibility
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both 1. Valid never depends on ready; the payload must stay stable while
// valid is high and ready is low. res_o/res_valid_o are held stable until
// taken.
// -----------------------------------------------------------------------------
module winograd_drain #(
   parameter  int IN_SIZE_0 = 8,
   parameter  int IN_SIZE_1 = 8,
   parameter  int NUM_TILES = 4,
   localparam int OUT_SIZE  = ((IN_SIZE_1 + 1) * 2) + 6,
   localparam int RES_SIZE  = IN_SIZE_0 + IN_SIZE_1 + $clog2(8 * NUM_TILES) + 1,
   localparam int CNT_W     = $clog2(NUM_TILES + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     tile_valid_i,
   output logic                     tile_ready_o,
   input  logic [1:0][OUT_SIZE-1:0] pair_i,
   input  logic [OUT_SIZE-1:0]      corr_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [RES_SIZE-1:0]      res_o,
   output logic [CNT_W-1:0]         tile_cnt_o,
   output logic                     state_o
);

   // Internal sum width: wide enough for one contribution (two partials minus
   // a correction) and for NUM_TILES of them, so nothing wraps before the
   // final truncation to RES_SIZE, which is exact for a true dot product.
   localparam int SUM_W = ((OUT_SIZE + 2) > RES_SIZE) ? (OUT_SIZE + 2) : RES_SIZE;
   localparam int ACC_W = SUM_W + $clog2(NUM_TILES);

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  contrib;
   logic signed [ACC_W-1:0]  acc_sum;
   logic                     is_final;
   logic                     take;

   assign contrib = ACC_W'($signed(pair_i[0]))
                  + ACC_W'($signed(pair_i[1]))
                  - ACC_W'($signed(corr_i));
   assign acc_sum = acc + contrib;

   assign is_final = (tile_cnt_o == CNT_W'(NUM_TILES - 1));

   // Only the final tile needs the result slot, so only it stalls behind an
   // untaken result. A pop in the same cycle frees the slot for it.
   assign tile_ready_o = !(is_final && res_valid_o && !res_ready_i);

   // clear_i wins over a presented tile: the tile is dropped.
   assign take = tile_valid_i && tile_ready_o && !clear_i;

   assign state_o = state;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         acc         <= '0;
         tile_cnt_o  <= '0;
         res_o       <= '0;
         res_valid_o <= 1'b0;
      end else begin
         // Result slot drains first; a final tile below may reload it in the
         // same cycle, keeping res_valid_o high.
         if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
            res_o       <= '0;
         end

         if (clear_i) begin
            acc        <= '0;
            tile_cnt_o <= '0;
            state      <= IDLE;
         end else if (take) begin
            if (is_final) begin
               res_o       <= acc_sum[RES_SIZE-1:0];
               res_valid_o <= 1'b1;
               acc         <= '0;
               tile_cnt_o  <= '0;
               state       <= IDLE;
            end else begin
               acc        <= acc_sum;
               tile_cnt_o <= tile_cnt_o + CNT_W'(1);
               state      <= ACCUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_winograd_drain.sv
module tb_winograd_drain;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (NUM_TILES=4) ----------------
   logic             clear;
   logic             tile_valid;
   logic             tile_ready;
   logic [1:0][23:0] pair;
   logic [23:0]      corr;
   logic             res_valid;
   logic             res_ready;
   logic [21:0]      res;
   logic [2:0]       tile_cnt;
   logic             state;

   winograd_drain #(.IN_SIZE_0(8), .IN_SIZE_1(8), .NUM_TILES(4)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear),
      .tile_valid_i (tile_valid),
      .tile_ready_o (tile_ready),
      .pair_i       (pair),
      .corr_i       (corr),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_o        (res),
      .tile_cnt_o   (tile_cnt),
      .state_o      (state)
   );

   // ---------------- DUT (NUM_TILES=1) ----------------
   logic             clear1;
   logic             tile_valid1;
   logic             tile_ready1;
   logic [1:0][23:0] pair1;
   logic [23:0]      corr1;
   logic             res_valid1;
   logic             res_ready1;
   logic [19:0]      res1;
   logic [0:0]       tile_cnt1;
   logic             state1;

   winograd_drain #(.IN_SIZE_0(8), .IN_SIZE_1(8), .NUM_TILES(1)) dut1 (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear1),
      .tile_valid_i (tile_valid1),
      .tile_ready_o (tile_ready1),
      .pair_i       (pair1),
      .corr_i       (corr1),
      .res_valid_o  (res_valid1),
      .res_ready_i  (res_ready1),
      .res_o        (res1),
      .tile_cnt_o   (tile_cnt1),
      .state_o      (state1)
   );

   // ---------------- scoreboard ----------------
   logic [21:0] exp_q[$];
   logic [19:0] exp1_q[$];
   int          tests_run;
   int          tests_failed;
   bit          rand_ready;

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL res_unexpected: got %0d, no result expected", $signed(res));
         end else begin
            logic [21:0] e;
            e = exp_q.pop_front();
            if (res !== e) begin
               tests_failed++;
               $display("FAIL res_scoreboard: got %0d expected %0d", $signed(res), $signed(e));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && res_valid1 && res_ready1) begin
         tests_run++;
         if (exp1_q.size() == 0) begin
            tests_failed++;
            $display("FAIL res1_unexpected: got %0d, no result expected", $signed(res1));
         end else begin
            logic [19:0] e;
            e = exp1_q.pop_front();
            if (res1 !== e) begin
               tests_failed++;
               $display("FAIL res1_scoreboard: got %0d expected %0d", $signed(res1), $signed(e));
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         res_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- model helpers ----------------
   // Winograd core outputs for one 8-lane tile: {out[1], out[0], corr}.
   function automatic logic [71:0] enc(input logic [63:0] av, input logic [63:0] bv);
      int a[8];
      int b[8];
      int p0, p1, c;
      for (int i = 0; i < 8; i++) begin
         a[i] = int'($signed(av[i*8 +: 8]));
         b[i] = int'($signed(bv[i*8 +: 8]));
      end
      p0 = (a[0] + b[1]) * (a[1] + b[0]) + (a[2] + b[3]) * (a[3] + b[2]);
      p1 = (a[4] + b[5]) * (a[5] + b[4]) + (a[6] + b[7]) * (a[7] + b[6]);
      c  = 0;
      for (int j = 0; j < 4; j++)
         c += a[2*j] * a[2*j+1] + b[2*j] * b[2*j+1];
      return {p1[23:0], p0[23:0], c[23:0]};
   endfunction

   // Plain dot product over the first n lanes.
   function automatic int golden(input logic [255:0] av, input logic [255:0] bv, input int n);
      int s;
      s = 0;
      for (int i = 0; i < n; i++)
         s += int'($signed(av[i*8 +: 8])) * int'($signed(bv[i*8 +: 8]));
      return s;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_tile(input logic [63:0] av, input logic [63:0] bv, input int gap);
      logic [71:0] e;
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      e = enc(av, bv);
      pair = e[71:24];
      corr = e[23:0];
      tile_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (tile_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) begin
         tests_run++; tests_failed++;
         $display("FAIL tile_accept_timeout: tile_ready=%b required 1", tile_ready);
      end
      @(posedge clk); #1;
      tile_valid = 1'b0;
   endtask

   task automatic send_tile1(input logic [63:0] av, input logic [63:0] bv);
      logic [71:0] e;
      int n;
      e = enc(av, bv);
      pair1 = e[71:24];
      corr1 = e[23:0];
      tile_valid1 = 1'b1;
      n = 0;
      @(negedge clk);
      while (tile_ready1 !== 1'b1 && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) begin
         tests_run++; tests_failed++;
         $display("FAIL tile1_accept_timeout: tile_ready=%b required 1", tile_ready1);
      end
      @(posedge clk); #1;
      tile_valid1 = 1'b0;
   endtask

   task automatic send_product(input logic [255:0] at, input logic [255:0] bt,
                               input int gap_max, input bit do_push);
      if (do_push) exp_q.push_back(22'(golden(at, bt, 32)));
      for (int t = 0; t < 4; t++)
         send_tile(at[t*64 +: 64], bt[t*64 +: 64], $urandom_range(0, gap_max));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; clear = 0; tile_valid = 0; pair = '0; corr = '0; res_ready = 0;
      clear1 = 0; tile_valid1 = 0; pair1 = '0; corr1 = '0; res_ready1 = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      tests_run += 4;
      if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
      if (res !== 22'd0) begin tests_failed++; $display("FAIL reset_res: got %0d required 0", res); end
      if (tile_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_tile_cnt: got %0d required 0", tile_cnt); end
      if (tile_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tile_ready: got %b required 1", tile_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      logic [255:0] at;
      at = {32{8'h7f}};
      res_ready = 1'b1;
      exp_q.push_back(22'(516128));
      for (int t = 0; t < 3; t++) send_tile(at[t*64 +: 64], at[t*64 +: 64], 0);
      tests_run += 3;
      if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_early_valid: got %b required 0", res_valid); end
      if (tile_cnt !== 3'd3) begin tests_failed++; $display("FAIL lat_tile_cnt: got %0d required 3", tile_cnt); end
      if (state !== 1'b1) begin tests_failed++; $display("FAIL lat_state: got %b required 1 (ACCUM)", state); end
      send_tile(at[192 +: 64], at[192 +: 64], 0);
      tests_run += 3;
      if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_valid: got %b required 1", res_valid); end
      if (res !== 22'(516128)) begin tests_failed++; $display("FAIL lat_res: got %0d required 516128", $signed(res)); end
      if (tile_cnt !== 3'd0) begin tests_failed++; $display("FAIL lat_cnt_wrap: got %0d required 0", tile_cnt); end
   endtask

   task automatic test_corners();
      logic [255:0] an, ap;
      an = {32{8'h80}};
      ap = {32{8'h7f}};
      res_ready = 1'b1;
      exp_q.push_back(22'(524288));
      send_product(an, an, 0, 1'b0);
      tests_run++;
      if (res !== 22'(524288)) begin tests_failed++; $display("FAIL corner_neg_neg: got %0d required 524288", $signed(res)); end
      exp_q.push_back(22'(-520192));
      send_product(ap, an, 1, 1'b0);
      tests_run++;
      if (res !== 22'(-520192)) begin tests_failed++; $display("FAIL corner_pos_neg: got %0d required -520192", $signed(res)); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      logic [255:0] a1, b1, a2, b2;
      logic [21:0]  e1, e2;
      logic [71:0]  e;
      a1 = rand256(); b1 = rand256(); a2 = rand256(); b2 = rand256();
      e1 = 22'(golden(a1, b1, 32));
      e2 = 22'(golden(a2, b2, 32));
      res_ready = 1'b0;
      send_product(a1, b1, 0, 1'b1);
      exp_q.push_back(e2);
      for (int t = 0; t < 3; t++) send_tile(a2[t*64 +: 64], b2[t*64 +: 64], 0);
      tests_run += 2;
      if (tile_cnt !== 3'd3) begin tests_failed++; $display("FAIL stall_cnt: got %0d required 3", tile_cnt); end
      if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_pending: got %b required 1", res_valid); end
      e = enc(a2[192 +: 64], b2[192 +: 64]);
      pair = e[71:24]; corr = e[23:0]; tile_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run += 2;
         if (tile_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready: got %b required 0", tile_ready); end
         if (res !== e1) begin tests_failed++; $display("FAIL stall_hold: got %0d required %0d", $signed(res), $signed(e1)); end
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (tile_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release: got %b required 1", tile_ready); end
      @(posedge clk); #1 tile_valid = 1'b0;
      tests_run += 2;
      if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL pop_load_valid: got %b required 1", res_valid); end
      if (res !== e2) begin tests_failed++; $display("FAIL pop_load_res: got %0d required %0d", $signed(res), $signed(e2)); end
      @(posedge clk); #1;
   endtask

   task automatic test_clear();
      logic [255:0] a, b;
      logic [71:0]  e;
      a = rand256(); b = rand256();
      res_ready = 1'b1;
      send_tile(a[0 +: 64], b[0 +: 64], 0);
      send_tile(a[64 +: 64], b[64 +: 64], 0);
      tests_run++;
      if (tile_cnt !== 3'd2) begin tests_failed++; $display("FAIL clear_pre_cnt: got %0d required 2", tile_cnt); end
      e = enc(a[128 +: 64], b[128 +: 64]);
      pair = e[71:24]; corr = e[23:0]; tile_valid = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      tile_valid = 1'b0; clear = 1'b0;
      tests_run++;
      if (tile_cnt !== 3'd0) begin tests_failed++; $display("FAIL clear_cnt: got %0d required 0", tile_cnt); end
      send_product('0, '0, 0, 1'b1);
      tests_run += 2;
      if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL clear_zero_valid: got %b required 1", res_valid); end
      if (res !== 22'd0) begin tests_failed++; $display("FAIL clear_zero_res: got %0d required 0", $signed(res)); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [255:0] a, b;
      a = rand256(); b = rand256();
      res_ready = 1'b0;
      send_product(rand256(), rand256(), 0, 1'b1);
      for (int t = 0; t < 3; t++) send_tile(a[t*64 +: 64], b[t*64 +: 64], 0);
      tests_run++;
      if (tile_cnt !== 3'd3) begin tests_failed++; $display("FAIL rstmid_pre_cnt: got %0d required 3", tile_cnt); end
      rst_n = 1'b0;
      #1;
      tests_run += 4;
      if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid: got %b required 0", res_valid); end
      if (tile_cnt !== 3'd0) begin tests_failed++; $display("FAIL rstmid_cnt: got %0d required 0", tile_cnt); end
      if (res !== 22'd0) begin tests_failed++; $display("FAIL rstmid_res: got %0d required 0", $signed(res)); end
      if (tile_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b required 1", tile_ready); end
      exp_q.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      res_ready = 1'b1;
      send_product(rand256(), rand256(), 0, 1'b1);
      tests_run++;
      if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_after: got %b required 1", res_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int n;
      rand_ready = 1'b1;
      for (int p = 0; p < 250; p++) send_product(rand256(), rand256(), 3, 1'b1);
      rand_ready = 1'b0;
      @(posedge clk); #2;
      res_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL random_drain: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_single_tile();
      logic [255:0] a, b;
      for (int k = 0; k < 8; k++) begin
         a = rand256(); b = rand256();
         exp1_q.push_back(20'(golden(a, b, 8)));
         send_tile1(a[63:0], b[63:0]);
         tests_run += 2;
         if (res_valid1 !== 1'b1) begin tests_failed++; $display("FAIL nt1_valid: got %b required 1", res_valid1); end
         if (tile_cnt1 !== 1'b0) begin tests_failed++; $display("FAIL nt1_cnt: got %0d required 0", tile_cnt1); end
      end
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (exp1_q.size() != 0 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL final_drain: outstanding %0d/%0d, required 0/0", exp_q.size(), exp1_q.size());
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      tests_run = 0;
      tests_failed = 0;
      rand_ready = 1'b0;
      test_reset();
      test_latency();
      test_corners();
      test_stall();
      test_clear();
      test_reset_mid();
      test_random();
      test_single_tile();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
